serial_borrow_subtractor: RTL and testbench



---
 rtl/serial_borrow_subtractor.sv | 150 +++++++++++++++
 tb/tb_serial_borrow_subtractor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor computing diff = a - b - bin, one bit per clock, LSB first.
// Define SUB_OVERFLOW_FLAG_EN to add the two's-complement overflow output ovf.
module serial_borrow_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] res_sr_q, res_sr_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_cat;

  // Single full-subtractor cell fed from the operand LSBs.
  assign a_bit    = a_sr_q[0];
  assign b_bit    = b_sr_q[0];
  assign d_bit    = a_bit ^ b_bit ^ br_q;
  assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign last_bit = (state_q == StRun) && (cnt_q == LastBit);

  // New bit enters at the MSB end; only WIDTH-1 earlier bits need storing.
  assign res_cat  = {d_bit, res_sr_q};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        res_sr_d = res_cat[WIDTH-1:1];
        br_d     = br_next;
        cnt_d    = cnt_q + 1'b1;
        if (last_bit) begin
          diff_d  = res_cat;
          bout_d  = br_next;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;

`ifdef SUB_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;

  // Signed overflow: borrow into the MSB differs from the borrow out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) begin
      ovf_d = br_q ^ br_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Overflow tracking compiled out; no extra state.
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor: directed vectors, backpressure,
// mid-run reset and randomized traffic against an arithmetic reference model.
module tb_serial_borrow_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   lat;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model from integer arithmetic on unsigned and signed views.
  function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv, logic bi);
    exp_t e;
    int   ua, ub, sa, sb, r;
    ua = int'(av);
    ub = int'(bv);
    r  = ua - ub - int'(bi);
    if (r < 0) r = r + 2 ** W;
    e.diff = r[W-1:0];
    e.bout = (ua < ub + int'(bi));
    sa = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
    sb = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
    r  = sa - sb - int'(bi);
    e.ovf = (r < -(2 ** (W - 1))) || (r > 2 ** (W - 1) - 1);
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every completed output handshake is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got diff=%0h with no pending expectation", diff);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_diff", 32'(diff), 32'(mon_e.diff));
        check("sb_bout", 32'(bout), 32'(mon_e.bout));
`ifdef SUB_OVERFLOW_FLAG_EN
        check("sb_ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
      end
    end
  end

  task automatic send(logic [W-1:0] av, logic [W-1:0] bv, logic bi);
    int n = 0;
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    while (!in_ready && n < 4 * W) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(model(av, bv, bi));
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    bin      = 1'($urandom);
  endtask

  task automatic wait_result(output int n);
    n = 1;
    while (!out_valid && n < 4 * W) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic release_out(int stall);
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);

    // Basic subtraction with latency check.
    send(8'h50, 8'h20, 1'b0);
    wait_result(lat);
    check("basic_latency", 32'(lat), 32'(W + 1));
    check("basic_diff", 32'(diff), 32'h30);
    check("basic_bout", 32'(bout), 32'd0);
    release_out(0);

    send(8'h00, 8'h01, 1'b0);
    wait_result(lat);
    check("underflow_diff", 32'(diff), 32'hFF);
    check("underflow_bout", 32'(bout), 32'd1);
    release_out(0);

    send(8'h05, 8'h05, 1'b1);
    wait_result(lat);
    check("borrow_in_diff", 32'(diff), 32'hFF);
    check("borrow_in_bout", 32'(bout), 32'd1);
    release_out(0);

    send(8'h80, 8'h01, 1'b0);
    wait_result(lat);
    check("ovf_vec_diff", 32'(diff), 32'h7F);
    check("ovf_vec_bout", 32'(bout), 32'd0);
`ifdef SUB_OVERFLOW_FLAG_EN
    check("ovf_vec_ovf", 32'(ovf), 32'd1);
`endif
    release_out(0);

    send(8'h30, 8'h10, 1'b0);
    wait_result(lat);
    check("no_ovf_diff", 32'(diff), 32'h20);
`ifdef SUB_OVERFLOW_FLAG_EN
    check("no_ovf_ovf", 32'(ovf), 32'd0);
`endif
    release_out(0);

    // Backpressure: result held, new operands ignored while stalled.
    send(8'h50, 8'h20, 1'b0);
    wait_result(lat);
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_diff", 32'(diff), 32'h30);
      check("stall_bout", 32'(bout), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_idle_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    send(8'h33, 8'h11, 1'b0);
    wait_result(lat);
    check("after_stall_diff", 32'(diff), 32'h22);
    release_out(0);

    // Reset during the 4th RUN cycle aborts the operation.
    send(8'h77, 8'h22, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    send(8'h10, 8'h01, 1'b0);
    wait_result(lat);
    check("midrst_latency", 32'(lat), 32'(W + 1));
    check("midrst_next_diff", 32'(diff), 32'h0F);
    release_out(0);

    // Randomized traffic with random output stalls.
    for (int i = 0; i < 150; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      wait_result(lat);
      check("rand_latency", 32'(lat), 32'(W + 1));
      release_out(int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
